serial_loader: RTL and testbench
================================

// Module: serial_loader
// PURPOSE
//  UART-driven monitor sitting upstream of the cpu: loads program bytes into the shared RAM,
//  dumps RAM, and launches the cpu at a given address via its start/rst input.
//  Owns the RAM port and UART while the cpu is not running; releases both between 'G' and halt.
//  Top level muxes RAM and UART signals on owns_bus.
// PARAMETERS
//  addr_width  9  RAM address width; must match the cpu instance.
// PORTS
//  clk             in   1           system clock, all logic on posedge.
//  rst             in   1           asynchronous, active-low reset.
//  received        in   1           1-cycle pulse from UART rx: rx_byte valid.
//  rx_byte         in   8           received byte.
//  is_transmitting in   1           UART tx busy.
//  tx_byte         out  8           byte to transmit.
//  transmit        out  1           1-cycle pulse: start transmitting tx_byte.
//  raddr           out  addr_width  RAM read address.
//  waddr           out  addr_width  RAM write address.
//  dwrite          out  8           RAM write data.
//  write_en        out  1           RAM write strobe, 1 cycle per byte.
//  dread           in   8           RAM read data.
//  cpu_start       out  1           1-cycle pulse to cpu rst input (launch).
//  startaddr       out  addr_width  launch address, held stable while running.
//  halted          in   1           1-cycle pulse from cpu on HLT.
//  owns_bus        out  1           1 = loader drives RAM/UART; 0 = cpu running.
// BEHAVIOUR
//  Reset: all outputs 0 except owns_bus=1. State=IDLE. cmd/addr/len regs = 0.
//  Protocol (bytes on rx):
//   'W'(0x57) AH AL N d0..dN-1 : write N bytes from {AH,AL}. Then send '.'(0x2E).
//   'R'(0x52) AH AL N : send N bytes read from {AH,AL}. No trailing ack.
//   'G'(0x47) AH AL : startaddr<={AH,AL}; pulse cpu_start; owns_bus<=0; state RUN.
//   Other first byte: send '?'(0x3F), back to IDLE.
//  Address = {AH,AL}[addr_width-1:0]; upper bits ignored. Increments modulo 2^addr_width (wraps).
//  N=0 means 256 bytes. Length counter is 9 bits.
//  States: IDLE, ADDRH, ADDRL, LEN, WDATA, RADDR, RWAIT, RDATA, TXWAIT, TXHOLD, RUN.
//   IDLE --received--> ADDRH, latch cmd; unknown cmd -> TXWAIT with '?'.
//   ADDRH/ADDRL/LEN advance on received. 'G' skips LEN: leaves ADDRL directly to RUN.
//   WDATA: each received -> waddr<=addr, dwrite<=rx_byte, write_en=1 one cycle; addr++, cnt--.
//    When cnt reaches 0 -> TXWAIT with '.'.
//   RADDR: raddr<=addr. RWAIT: one wait cycle. RDATA: tx_byte<=dread, addr++, cnt--, -> TXWAIT.
//    RAM read latency is 2 clocks from raddr register to dread sample.
//   TXWAIT: when !is_transmitting, transmit=1 for 1 cycle -> TXHOLD.
//   TXHOLD: 1 dead cycle (busy flag lags transmit by one clock).
//    Next state: RADDR if reading and cnt!=0, else IDLE.
//   RUN: received ignored; RAM/UART outputs held 0. On halted: owns_bus<=1, send 'H'(0x48) via TXWAIT.
//  Simultaneous: received during TXWAIT/TXHOLD/RADDR/RWAIT/RDATA is dropped (host must pace).
//  halted outside RUN is ignored. cpu_start is asserted in exactly one cycle per 'G'.
//  owns_bus falls in the same cycle cpu_start pulses.
//  Reset mid-operation: immediate return to IDLE, owns_bus=1, partially loaded data left in RAM.
// STRUCTURE
//  Shared include loader_defs.vh: command codes (W/R/G), ack codes ('.', '?', 'H'), state localparams.
//  Single flat FSM module, no sub-module; address/length counters inline.
// TESTING
//  'W' 01 00 03 AA BB CC -> writes AA@0x100, BB@0x101, CC@0x102, 3 write_en pulses, then tx '.'.
//  'R' 01 00 03 after above -> tx AA,BB,CC in order, each transmit only when !is_transmitting.
//  'W' 01 FF 02 11 22 (addr_width=9) -> 11@0x1FF, 22@0x000 (wrap).
//  'W' 00 00 00 + 256 bytes -> 256 writes, then '.'.
//  'G' 00 10 -> startaddr=0x010, cpu_start 1 cycle, owns_bus=0.
//   Bytes received while running are ignored; halted pulse -> owns_bus=1, tx 'H'.
//  0x5A -> tx '?'. Reset asserted mid-'W' -> IDLE, owns_bus=1, then a fresh 'R' works.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// Shared definitions for the UART serial loader: command/ack byte codes,
// FSM state encoding and a small command-decode helper.
package serial_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] ACK_DONE  = 8'h2E;
    localparam logic [7:0] ACK_ERR   = 8'h3F;
    localparam logic [7:0] ACK_HALT  = 8'h48;

    localparam int CNT_W = 9;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDRH  = 4'd1,
        ST_ADDRL  = 4'd2,
        ST_LEN    = 4'd3,
        ST_WDATA  = 4'd4,
        ST_RADDR  = 4'd5,
        ST_RWAIT  = 4'd6,
        ST_RDATA  = 4'd7,
        ST_TXWAIT = 4'd8,
        ST_TXHOLD = 4'd9,
        ST_RUN    = 4'd10
    } state_e;

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ) || (b == CMD_GO);
    endfunction

endpackage

// File: rtl/serial_loader.sv
// UART-driven monitor: loads/dumps the shared RAM and launches the cpu.
// Owns the RAM port and UART except between a 'G' launch and the cpu halt.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    output logic [addr_width-1:0] raddr,
    output logic [addr_width-1:0] waddr,
    output logic [7:0]            dwrite,
    output logic                  write_en,
    input  logic [7:0]            dread,
    output logic                  cpu_start,
    output logic [addr_width-1:0] startaddr,
    input  logic                  halted,
    output logic                  owns_bus
);

    localparam logic [addr_width-1:0] ADDR_ONE  = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [addr_width-1:0] ADDR_ZERO = {addr_width{1'b0}};

    state_e                state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            ah_q, ah_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  transmit_q, transmit_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [7:0]            dwrite_q, dwrite_d;
    logic                  write_en_q, write_en_d;
    logic                  cpu_start_q, cpu_start_d;
    logic [addr_width-1:0] startaddr_q, startaddr_d;
    logic                  owns_bus_q, owns_bus_d;
    logic [15:0]           addr_full_s;

    assign addr_full_s = {ah_q, rx_byte};

    // State and output registers; owns_bus is the only output that resets high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            ah_q        <= 8'h00;
            addr_q      <= ADDR_ZERO;
            cnt_q       <= {CNT_W{1'b0}};
            tx_byte_q   <= 8'h00;
            transmit_q  <= 1'b0;
            raddr_q     <= ADDR_ZERO;
            waddr_q     <= ADDR_ZERO;
            dwrite_q    <= 8'h00;
            write_en_q  <= 1'b0;
            cpu_start_q <= 1'b0;
            startaddr_q <= ADDR_ZERO;
            owns_bus_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ah_q        <= ah_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tx_byte_q   <= tx_byte_d;
            transmit_q  <= transmit_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            dwrite_q    <= dwrite_d;
            write_en_q  <= write_en_d;
            cpu_start_q <= cpu_start_d;
            startaddr_q <= startaddr_d;
            owns_bus_q  <= owns_bus_d;
        end
    end

    // Next-state and registered-output decode for the command protocol.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ah_d        = ah_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tx_byte_d   = tx_byte_q;
        transmit_d  = 1'b0;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        dwrite_d    = dwrite_q;
        write_en_d  = 1'b0;
        cpu_start_d = 1'b0;
        startaddr_d = startaddr_q;
        owns_bus_d  = owns_bus_q;
        case (state_q)
            ST_IDLE: begin
                if (received) begin
                    cmd_d = rx_byte;
                    if (is_known_cmd(rx_byte)) begin
                        state_d = ST_ADDRH;
                    end else begin
                        tx_byte_d = ACK_ERR;
                        state_d   = ST_TXWAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDRH: begin
                if (received) begin
                    ah_d    = rx_byte;
                    state_d = ST_ADDRL;
                end else begin
                    state_d = ST_ADDRH;
                end
            end
            ST_ADDRL: begin
                if (received) begin
                    addr_d = addr_full_s[addr_width-1:0];
                    if (cmd_q == CMD_GO) begin
                        // Launch: bus outputs go quiet in the same cycle ownership drops.
                        startaddr_d = addr_full_s[addr_width-1:0];
                        cpu_start_d = 1'b1;
                        owns_bus_d  = 1'b0;
                        tx_byte_d   = 8'h00;
                        raddr_d     = ADDR_ZERO;
                        waddr_d     = ADDR_ZERO;
                        dwrite_d    = 8'h00;
                        state_d     = ST_RUN;
                    end else begin
                        state_d = ST_LEN;
                    end
                end else begin
                    state_d = ST_ADDRL;
                end
            end
            ST_LEN: begin
                if (received) begin
                    cnt_d   = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                    state_d = (cmd_q == CMD_WRITE) ? ST_WDATA : ST_RADDR;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_WDATA: begin
                if (received) begin
                    waddr_d    = addr_q;
                    dwrite_d   = rx_byte;
                    write_en_d = 1'b1;
                    addr_d     = addr_q + ADDR_ONE;
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        tx_byte_d = ACK_DONE;
                        state_d   = ST_TXWAIT;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RADDR: begin
                raddr_d = addr_q;
                state_d = ST_RWAIT;
            end
            // RAM data is valid two clocks after raddr is registered.
            ST_RWAIT: state_d = ST_RDATA;
            ST_RDATA: begin
                tx_byte_d = dread;
                addr_d    = addr_q + ADDR_ONE;
                cnt_d     = cnt_q - 9'd1;
                state_d   = ST_TXWAIT;
            end
            ST_TXWAIT: begin
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    state_d    = ST_TXHOLD;
                end else begin
                    state_d = ST_TXWAIT;
                end
            end
            ST_TXHOLD: begin
                if ((cmd_q == CMD_READ) && (cnt_q != 9'd0)) begin
                    state_d = ST_RADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halted) begin
                    owns_bus_d = 1'b1;
                    tx_byte_d  = ACK_HALT;
                    state_d    = ST_TXWAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_byte   = tx_byte_q;
    assign transmit  = transmit_q;
    assign raddr     = raddr_q;
    assign waddr     = waddr_q;
    assign dwrite    = dwrite_q;
    assign write_en  = write_en_q;
    assign cpu_start = cpu_start_q;
    assign startaddr = startaddr_q;
    assign owns_bus  = owns_bus_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader with a synchronous-read RAM model and a
// UART transmitter model that stays busy for a few cycles after each byte.
module tb_serial_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_transmitting;
    logic [7:0] tx_byte;
    logic       transmit;
    logic [8:0] raddr;
    logic [8:0] waddr;
    logic [7:0] dwrite;
    logic       write_en;
    logic [7:0] dread;
    logic       cpu_start;
    logic [8:0] startaddr;
    logic       halted;
    logic       owns_bus;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:511];
    logic [7:0] tx_log [0:63];
    int tx_cnt = 0;
    int busy_left = 0;
    int tx_viol = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int bus_viol = 0;

    serial_loader #(.addr_width(9)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
        .raddr(raddr), .waddr(waddr), .dwrite(dwrite), .write_en(write_en),
        .dread(dread), .cpu_start(cpu_start), .startaddr(startaddr),
        .halted(halted), .owns_bus(owns_bus)
    );

    always #5 clk = ~clk;

    assign is_transmitting = (busy_left > 0);

    // RAM with 1-clock registered read, UART busy model and event counters.
    always @(posedge clk) begin
        dread <= mem[raddr];
        if (write_en) begin
            mem[waddr] <= dwrite;
            wr_cnt     <= wr_cnt + 1;
            if (!owns_bus) bus_viol <= bus_viol + 1;
        end
        if (transmit) begin
            if (is_transmitting) tx_viol <= tx_viol + 1;
            tx_log[tx_cnt[5:0]] <= tx_byte;
            tx_cnt    <= tx_cnt + 1;
            busy_left <= 4;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
        if (cpu_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        received = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int i = 0; i < 3000 && tx_cnt < n; i++) @(negedge clk);
        check(tag, tx_cnt, n);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int wr_base;
        logic [7:0] b;
        rst      = 1'b0;
        received = 1'b0;
        rx_byte  = 8'h00;
        halted   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_transmit", transmit, 1'b0);
        check("rst_write_en", write_en, 1'b0);
        check("rst_cpu_start", cpu_start, 1'b0);
        check("rst_startaddr", startaddr, 9'h000);
        check("rst_raddr_waddr", {raddr, waddr}, 18'h0);
        check("rst_owns_bus", owns_bus, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // W 01 00 03 AA BB CC
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_tx(1, "w_ack_count");
        check("w_ack", tx_log[0], 8'h2E);
        check("w_mem100", mem[9'h100], 8'hAA);
        check("w_mem101", mem[9'h101], 8'hBB);
        check("w_mem102", mem[9'h102], 8'hCC);
        check("w_pulses", wr_cnt, 3);

        // R 01 00 03
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        wait_tx(4, "r_count");
        check("r_byte0", tx_log[1], 8'hAA);
        check("r_byte1", tx_log[2], 8'hBB);
        check("r_byte2", tx_log[3], 8'hCC);

        // W 01 FF 02 11 22: address wraps
        send_byte(8'h57); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        wait_tx(5, "wrap_count");
        check("wrap_ack", tx_log[4], 8'h2E);
        check("wrap_mem1ff", mem[9'h1FF], 8'h11);
        check("wrap_mem000", mem[9'h000], 8'h22);

        // W 00 00 00 + 256 bytes
        wr_base = wr_cnt;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0] + 8'd3;
            send_byte(b);
        end
        wait_tx(6, "n256_count");
        check("n256_ack", tx_log[5], 8'h2E);
        check("n256_writes", wr_cnt - wr_base, 256);
        check("n256_mem000", mem[9'h000], 8'h03);
        check("n256_mem0ff", mem[9'h0FF], 8'h02);
        check("n256_no_overrun", mem[9'h100], 8'hAA);

        // Unknown command
        send_byte(8'h5A);
        wait_tx(7, "unk_count");
        check("unk_ack", tx_log[6], 8'h3F);

        // G 00 10, run, ignored bytes, halt
        wr_base = wr_cnt;
        send_byte(8'h47); send_byte(8'h00); send_byte(8'h10);
        check("go_startaddr", startaddr, 9'h010);
        check("go_owns_bus", owns_bus, 1'b0);
        check("go_start_pulses", start_cnt, 1);
        check("go_tx_byte_quiet", tx_byte, 8'h00);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (10) @(negedge clk);
        check("run_ignore_tx", tx_cnt, 7);
        check("run_ignore_wr", wr_cnt - wr_base, 0);
        check("run_owns_bus", owns_bus, 1'b0);
        check("run_startaddr_held", startaddr, 9'h010);
        @(negedge clk); halted = 1'b1;
        @(negedge clk); halted = 1'b0;
        wait_tx(8, "halt_count");
        check("halt_ack", tx_log[7], 8'h48);
        check("halt_owns_bus", owns_bus, 1'b1);
        check("halt_start_pulses", start_cnt, 1);

        // Reset mid-W, then fresh read of the partially loaded data
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
        send_byte(8'h77);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_owns_bus", owns_bus, 1'b1);
        check("mid_rst_write_en", write_en, 1'b0);
        check("mid_rst_partial", mem[9'h020], 8'h77);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
        wait_tx(9, "post_rst_count");
        check("post_rst_read", tx_log[8], 8'h77);

        check("tx_while_busy", tx_viol, 0);
        check("write_without_bus", bus_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
